// File: rtl/word_deaggregator_pkg.sv
// Shared definitions for the word de-aggregator slice.
// Holds the default word/fetch geometry, the control FSM state encoding and
// a helper that sizes the word index for a given fetch width.
package word_deaggregator_pkg;

   localparam int DEF_DATA_WIDTH  = 16;
   localparam int DEF_FETCH_WIDTH = 4;
   localparam int IDX_W           = $clog2(DEF_FETCH_WIDTH);

   // IDLE: buffer empty, WAIT: fetch data arriving, EMIT: pushing words out
   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      EMIT
   } state_t;

   // Index width for a fetch of n words; never narrower than one bit
   function automatic int idxWidth(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/word_deaggregator_fifo.sv
// Small show-ahead FIFO used as the per-word receiver behind the
// de-aggregator.
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   clr          synchronous flush (wins over enq/deq in the same cycle)
//   din, enq     write data and write strobe (ignored when full)
//   deq          pop strobe (ignored when empty)
//   dout         head entry, valid whenever empty_n is high
//   full_n       high when there is room for another entry
//   empty_n      high when at least one entry is stored
module fifo #(
   parameter int DATA_WIDTH    = 16,
   parameter int FIFO_DEPTH    = 3,
   parameter int COUNTER_WIDTH = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clr,
   input  logic [DATA_WIDTH-1:0] din,
   input  logic                  enq,
   input  logic                  deq,
   output logic [DATA_WIDTH-1:0] dout,
   output logic                  full_n,
   output logic                  empty_n
);

   // The occupancy counter must reach FIFO_DEPTH itself, so a caller-supplied
   // width that is too narrow is widened here.
   localparam int NEEDED_W = $clog2(FIFO_DEPTH + 1);
   localparam int CNT_W    = (COUNTER_WIDTH > NEEDED_W) ? COUNTER_WIDTH : NEEDED_W;
   localparam int PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);

   logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]      wrPtr_q, rdPtr_q;
   logic [CNT_W-1:0]      count_q;
   logic                  doEnq, doDeq;

   function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
      return (p == LAST_PTR) ? '0 : p + 1'b1;
   endfunction

   // Status flags come straight from the occupancy count; the head entry is
   // shown ahead so a consumer can look before popping.
   always_comb begin
      full_n  = (count_q != CNT_W'(FIFO_DEPTH));
      empty_n = (count_q != '0);
      doEnq   = enq && full_n;
      doDeq   = deq && empty_n;
      dout    = mem_q[rdPtr_q];
   end

   // Circular storage: pointers wrap at the depth rather than at a power of
   // two, and a simultaneous push and pop leaves the count unchanged.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (clr) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
      end else begin
         if (doEnq) begin
            mem_q[wrPtr_q] <= din;
            wrPtr_q        <= nextPtr(wrPtr_q);
         end
         if (doDeq) begin
            rdPtr_q <= nextPtr(rdPtr_q);
         end
         if (doEnq && !doDeq) begin
            count_q <= count_q + 1'b1;
         end else if (!doEnq && doDeq) begin
            count_q <= count_q - 1'b1;
         end
      end
   end

endmodule

// File: rtl/word_deaggregator.sv
// Splits one wide fetch of FETCH_WIDTH words into single DATA_WIDTH words and
// pushes them, word 0 first, into a narrow downstream FIFO at one per cycle.
// Ports:
//   clk, rst_n        clock and asynchronous active-low reset
//   sender_data       wide fetch, word i at [(i+1)*DATA_WIDTH-1 : i*DATA_WIDTH]
//   sender_empty_n    sender has a fetch available
//   sender_deq        one-cycle pop/request; data is valid one cycle later
//   receiver_data     word currently offered downstream
//   receiver_full_n   downstream can accept a word this cycle
//   receiver_enq      word pushed downstream this cycle
module word_deaggregator
   import word_deaggregator_pkg::*;
#(
   parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
   parameter int FETCH_WIDTH = DEF_FETCH_WIDTH
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic [FETCH_WIDTH*DATA_WIDTH-1:0] sender_data,
   input  logic                              sender_empty_n,
   output logic                              sender_deq,
   output logic [DATA_WIDTH-1:0]             receiver_data,
   input  logic                              receiver_full_n,
   output logic                              receiver_enq
);

   localparam int IW = idxWidth(FETCH_WIDTH);
   localparam logic [IW-1:0] LAST_IDX = IW'(FETCH_WIDTH - 1);

   state_t                state_q, state_d;
   logic [IW-1:0]         idx_q, idx_d;
   logic [DATA_WIDTH-1:0] fetchBuf_q [FETCH_WIDTH];
   logic                  capture;
   logic                  deqReq;
   logic                  enqReq;

   // Next-state logic. The pop for the following fetch is issued in the same
   // cycle as the last word is pushed, so back-to-back fetches cost only the
   // single WAIT cycle of request latency.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      capture = 1'b0;
      deqReq  = 1'b0;
      enqReq  = 1'b0;
      case (state_q)
         IDLE: begin
            deqReq = sender_empty_n;
            if (sender_empty_n) begin
               state_d = WAIT;
            end
         end
         WAIT: begin
            capture = 1'b1;
            idx_d   = '0;
            state_d = EMIT;
         end
         EMIT: begin
            enqReq = receiver_full_n;
            if (receiver_full_n) begin
               if (idx_q == LAST_IDX) begin
                  idx_d = '0;
                  if (sender_empty_n) begin
                     deqReq  = 1'b1;
                     state_d = WAIT;
                  end else begin
                     state_d = IDLE;
                  end
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
            idx_d   = '0;
         end
      endcase
   end

   // The strobes are masked by reset as well, so neither FIFO sees a push or
   // pop while reset is held even though IDLE would otherwise request.
   always_comb begin
      sender_deq    = rst_n & deqReq;
      receiver_enq  = rst_n & enqReq;
      receiver_data = fetchBuf_q[idx_q];
   end

   // FSM state and word index registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   // The fetch buffer is loaded only in WAIT, i.e. on the edge that ends the
   // cycle after the pop, when the sender already shows the popped fetch.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < FETCH_WIDTH; i++) begin
            fetchBuf_q[i] <= '0;
         end
      end else if (capture) begin
         for (int i = 0; i < FETCH_WIDTH; i++) begin
            fetchBuf_q[i] <= sender_data[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

endmodule

// File: tb/tb_word_deaggregator.sv
// Bench for word_deaggregator with a receiver FIFO behind it and a second,
// standalone FIFO exercised from a vector table.
module tb_word_deaggregator;

   logic        clk;
   logic        rst_n;
   logic [63:0] sender_data;
   logic        sender_empty_n;
   logic        sender_deq;
   logic [15:0] receiver_data;
   logic        receiver_full_n;
   logic        receiver_enq;

   logic        forceFull;
   logic        rxFullN, rxEmptyN, consDeq;
   logic [15:0] rxDout;

   logic        tClr, tEnq, tDeq, tFullN, tEmptyN;
   logic [15:0] tDin, tDout;

   logic [15:0] senderBase;
   int          cycle;
   int          checkCount;
   int          passCount;
   int          wordsRx;
   int          expNext;
   int          consMode;
   int          lastDeq;
   bit          haveLast;
   bit          rateOn;

   typedef struct {
      logic        enq;
      logic        deq;
      logic        clr;
      logic [15:0] din;
      logic        expFullN;
      logic        expEmptyN;
      logic        chkDout;
      logic [15:0] expDout;
   } fifoVec_t;

   fifoVec_t vecs [10];

   word_deaggregator #(.DATA_WIDTH(16), .FETCH_WIDTH(4)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .sender_data     (sender_data),
      .sender_empty_n  (sender_empty_n),
      .sender_deq      (sender_deq),
      .receiver_data   (receiver_data),
      .receiver_full_n (receiver_full_n),
      .receiver_enq    (receiver_enq)
   );

   fifo #(.DATA_WIDTH(16), .FIFO_DEPTH(3), .COUNTER_WIDTH(2)) rxFifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (1'b0),
      .din     (receiver_data),
      .enq     (receiver_enq),
      .deq     (consDeq),
      .dout    (rxDout),
      .full_n  (rxFullN),
      .empty_n (rxEmptyN)
   );

   fifo #(.DATA_WIDTH(16), .FIFO_DEPTH(3), .COUNTER_WIDTH(1)) tFifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (tClr),
      .din     (tDin),
      .enq     (tEnq),
      .deq     (tDeq),
      .dout    (tDout),
      .full_n  (tFullN),
      .empty_n (tEmptyN)
   );

   assign receiver_full_n = rxFullN & ~forceFull;

   // The sender presents consecutive integers, four per fetch, starting with
   // {3,2,1,0}; every pop advances it to the next four.
   assign sender_data = {senderBase + 16'd3, senderBase + 16'd2,
                         senderBase + 16'd1, senderBase};

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Sender model: a pop takes effect on the clock edge that samples it.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         senderBase <= 16'd0;
      end else if (sender_deq) begin
         senderBase <= senderBase + 16'd4;
      end
   end

   always @(posedge clk) begin
      cycle <= cycle + 1;
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checkCount++;
      if (actual === expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
      end
   endtask

   // Consumer: pops the receiver FIFO (always, or on a coin flip) and checks
   // that the words come out as the unbroken integer sequence 4,5,6,...
   initial begin
      consDeq = 1'b0;
      expNext = 4;
      wordsRx = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            expNext = 4;
            consDeq = 1'b0;
         end else begin
            consDeq = (consMode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            if (consDeq && rxEmptyN) begin
               checkOutput("streamWord", 32'(rxDout), 32'(expNext));
               expNext++;
               wordsRx++;
            end
         end
      end
   end

   // Rate monitor: with an unstalled consumer a new fetch is requested every
   // FETCH_WIDTH+1 = 5 cycles.
   initial begin
      forever begin
         @(negedge clk);
         if (rateOn && rst_n && sender_deq) begin
            if (haveLast) begin
               checkOutput("deqInterval", 32'(cycle - lastDeq), 32'd5);
            end
            lastDeq  = cycle;
            haveLast = 1'b1;
         end
      end
   end

   task automatic applyReset();
      @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic applyStimulus(input fifoVec_t v);
      tEnq = v.enq;
      tDeq = v.deq;
      tClr = v.clr;
      tDin = v.din;
      @(negedge clk);
      tEnq = 1'b0;
      tDeq = 1'b0;
      tClr = 1'b0;
   endtask

   initial begin : mainSeq
      int  startWords;
      bit  found;
      bit  sawFull;
      bit  badEnq;
      int  idleDeq;
      int  idleEnq;
      bit  holdOk;
      bit  noEnqOk;

      checkCount     = 0;
      passCount      = 0;
      cycle          = 0;
      consMode       = 0;
      rateOn         = 1'b0;
      haveLast       = 1'b0;
      lastDeq        = 0;
      forceFull      = 1'b0;
      sender_empty_n = 1'b1;
      tClr = 1'b0; tEnq = 1'b0; tDeq = 1'b0; tDin = 16'd0;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;

      // Reset state with a fetch available: nothing may be requested or pushed
      repeat (2) @(negedge clk);
      checkOutput("rstSenderDeq", 32'(sender_deq), 32'd0);
      checkOutput("rstReceiverEnq", 32'(receiver_enq), 32'd0);
      checkOutput("rstReceiverData", 32'(receiver_data), 32'd0);

      // Unstalled streaming at full rate
      haveLast = 1'b0;
      rateOn   = 1'b1;
      rst_n    = 1'b1;
      #1;
      checkOutput("firstRequest", 32'(sender_deq), 32'd1);
      startWords = wordsRx;
      for (int i = 0; i < 200 && (wordsRx - startWords) < 40; i++) @(negedge clk);
      checkOutput("noStallWords", 32'((wordsRx - startWords) >= 40), 32'd1);
      rateOn = 1'b0;

      // Random consumer stalls and random sender gaps
      applyReset();
      consMode = 1;
      sawFull  = 1'b0;
      badEnq   = 1'b0;
      startWords = wordsRx;
      for (int i = 0; i < 3000 && (wordsRx - startWords) < 80; i++) begin
         @(negedge clk);
         sender_empty_n = ($urandom_range(0, 9) < 7);
         #1;
         if (!rxFullN) sawFull = 1'b1;
         if (!receiver_full_n && receiver_enq) badEnq = 1'b1;
      end
      checkOutput("stallWords", 32'((wordsRx - startWords) >= 80), 32'd1);
      checkOutput("stallSawFull", 32'(sawFull), 32'd1);
      checkOutput("stallNoEnqWhenFull", 32'(badEnq), 32'd0);
      consMode = 0;

      // Sender empty after reset: idle forever, then first word two cycles later
      sender_empty_n = 1'b0;
      applyReset();
      idleDeq = 0;
      idleEnq = 0;
      for (int i = 0; i < 12; i++) begin
         #1;
         if (sender_deq) idleDeq++;
         if (receiver_enq) idleEnq++;
         @(negedge clk);
      end
      checkOutput("emptyNoDeq", 32'(idleDeq), 32'd0);
      checkOutput("emptyNoEnq", 32'(idleEnq), 32'd0);
      sender_empty_n = 1'b1;
      #1;
      checkOutput("raiseDeq", 32'(sender_deq), 32'd1);
      @(negedge clk);
      checkOutput("raiseWaitEnq", 32'(receiver_enq), 32'd0);
      @(negedge clk);
      checkOutput("raiseFirstEnq", 32'(receiver_enq), 32'd1);
      checkOutput("raiseFirstWord", 32'(receiver_data), 32'd4);

      // Downstream forced full for 10 cycles after word 1 of a fetch
      applyReset();
      found = 1'b0;
      for (int i = 0; i < 50 && !found; i++) begin
         @(negedge clk);
         if (receiver_enq && receiver_data == 16'd5) found = 1'b1;
      end
      checkOutput("findWord1", 32'(found), 32'd1);
      @(negedge clk);
      forceFull = 1'b1;
      holdOk  = 1'b1;
      noEnqOk = 1'b1;
      for (int i = 0; i < 10; i++) begin
         #1;
         if (receiver_data !== 16'd6) holdOk = 1'b0;
         if (receiver_enq !== 1'b0) noEnqOk = 1'b0;
         @(negedge clk);
      end
      checkOutput("stallHoldData", 32'(holdOk), 32'd1);
      checkOutput("stallNoEnq", 32'(noEnqOk), 32'd1);
      forceFull = 1'b0;
      #1;
      checkOutput("resumeWord2", 32'(receiver_data), 32'd6);
      checkOutput("resumeEnq2", 32'(receiver_enq), 32'd1);
      @(negedge clk);
      checkOutput("resumeWord3", 32'(receiver_data), 32'd7);
      checkOutput("resumeDeq", 32'(sender_deq), 32'd1);
      @(negedge clk);
      checkOutput("resumeWaitEnq", 32'(receiver_enq), 32'd0);
      @(negedge clk);
      checkOutput("nextFetchWord", 32'(receiver_data), 32'd8);

      // Reset in the middle of a fetch (EMIT, idx=2)
      applyReset();
      found = 1'b0;
      for (int i = 0; i < 50 && !found; i++) begin
         @(negedge clk);
         if (receiver_enq && receiver_data == 16'd6) found = 1'b1;
      end
      checkOutput("findWord2", 32'(found), 32'd1);
      rst_n = 1'b0;
      #1;
      checkOutput("midRstDeq", 32'(sender_deq), 32'd0);
      checkOutput("midRstEnq", 32'(receiver_enq), 32'd0);
      checkOutput("midRstData", 32'(receiver_data), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      checkOutput("postRstRequest", 32'(sender_deq), 32'd1);
      checkOutput("postRstNoEnq", 32'(receiver_enq), 32'd0);
      @(negedge clk);
      checkOutput("postRstWaitEnq", 32'(receiver_enq), 32'd0);
      @(negedge clk);
      checkOutput("postRstFirstWord", 32'(receiver_data), 32'd4);
      repeat (20) @(negedge clk);

      // Standalone FIFO from a vector table
      vecs[0] = '{1'b1, 1'b0, 1'b0, 16'h0011, 1'b1, 1'b1, 1'b1, 16'h0011};
      vecs[1] = '{1'b1, 1'b0, 1'b0, 16'h0022, 1'b1, 1'b1, 1'b1, 16'h0011};
      vecs[2] = '{1'b1, 1'b0, 1'b0, 16'h0033, 1'b0, 1'b1, 1'b1, 16'h0011};
      vecs[3] = '{1'b1, 1'b0, 1'b0, 16'h0044, 1'b0, 1'b1, 1'b1, 16'h0011};
      vecs[4] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h0022};
      vecs[5] = '{1'b1, 1'b1, 1'b0, 16'h0055, 1'b1, 1'b1, 1'b1, 16'h0033};
      vecs[6] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h0055};
      vecs[7] = '{1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000};
      vecs[8] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000};
      vecs[9] = '{1'b1, 1'b0, 1'b0, 16'h0066, 1'b1, 1'b1, 1'b1, 16'h0066};
      applyReset();
      #1;
      checkOutput("fifoRstEmpty", 32'(tEmptyN), 32'd0);
      checkOutput("fifoRstFullN", 32'(tFullN), 32'd1);
      for (int i = 0; i < 10; i++) begin
         applyStimulus(vecs[i]);
         #1;
         checkOutput($sformatf("fifoVec%0d_fullN", i), 32'(tFullN), 32'(vecs[i].expFullN));
         checkOutput($sformatf("fifoVec%0d_emptyN", i), 32'(tEmptyN), 32'(vecs[i].expEmptyN));
         if (vecs[i].chkDout) begin
            checkOutput($sformatf("fifoVec%0d_dout", i), 32'(tDout), 32'(vecs[i].expDout));
         end
      end

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
